fetch_queue_unit: RTL

//  Parametrised instruction fetch front end: keeps one outstanding request to the memory controller.

---
 rtl/fetch_queue_unit_pkg.sv | 17 +
 rtl/fetch_queue_unit_iq.sv | 54 +++++
 rtl/fetch_queue_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and FSM encoding for the fetch queue unit.
// Opcode constants are consumed by the static predictor (FETCH_BPRED_EN).
package fetch_queue_unit_pkg;

  localparam int unsigned DataWidth = 32;
  localparam logic [DataWidth-1:0] ZeroData = '0;

  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitMem = 2'd1,
    StDrop    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_unit_iq.sv
// Circular instruction queue: push/pop/flush, occupancy count and head entry.
// Head data reads as zero while the queue is empty.
module fetch_iq #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [Width-1:0]       push_data,
  output logic [$clog2(Depth):0] count,
  output logic                   valid,
  output logic [Width-1:0]       head_data
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  always_comb begin
    count     = count_q;
    valid     = (count_q != '0);
    head_data = valid ? mem_q[head_q] : '0;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: one outstanding memory request, IQ_DEPTH-entry instruction queue, redirects.
// Define FETCH_BPRED_EN to enable static JAL / backward-branch prediction on push.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            out_mem_ce,
  output logic [XLEN-1:0] out_mem_pc,
  input  logic            in_mem_ce,
  input  logic [XLEN-1:0] in_mem_instr,
  input  logic            in_redirect_ce,
  input  logic [XLEN-1:0] in_redirect_pc,
  output logic            out_instr_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  input  logic            in_dec_ready
);

  localparam int unsigned     EntryW   = 2 * XLEN + 1;
  localparam int unsigned     CntW     = $clog2(IQ_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(IQ_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, mem_pc_q, mem_pc_d, next_pc;
  logic            mem_ce_q, mem_ce_d, pred;
  logic            iq_push, iq_pop, iq_flush, iq_valid;
  logic [CntW-1:0] iq_count;
  logic [EntryW-1:0] iq_head;

  fetch_iq #(
    .Width (EntryW),
    .Depth (IQ_DEPTH)
  ) u_iq (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .pop       (iq_pop),
    .flush     (iq_flush),
    .push_data ({in_mem_instr, pc_q, pred}),
    .count     (iq_count),
    .valid     (iq_valid),
    .head_data (iq_head)
  );

`ifdef FETCH_BPRED_EN
  logic [XLEN-1:0] imm_j, imm_b;

  always_comb begin
    imm_j = {{(XLEN-20){in_mem_instr[31]}}, in_mem_instr[19:12], in_mem_instr[20],
             in_mem_instr[30:21], 1'b0};
    imm_b = {{(XLEN-12){in_mem_instr[31]}}, in_mem_instr[7], in_mem_instr[30:25],
             in_mem_instr[11:8], 1'b0};
    next_pc = pc_q + XLEN'(4);
    pred    = 1'b0;
    if (in_mem_instr[6:0] == OpcJal) begin
      next_pc = pc_q + imm_j;
      pred    = 1'b1;
    end else if (in_mem_instr[6:0] == OpcBranch && in_mem_instr[31]) begin
      next_pc = pc_q + imm_b;
      pred    = 1'b1;
    end
  end
`else
  logic unused_pred;

  assign next_pc     = pc_q + XLEN'(4);
  assign pred        = 1'b0;
  assign unused_pred = iq_head[0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      mem_ce_q <= 1'b0;
      mem_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mem_ce_q <= mem_ce_d;
      mem_pc_q <= mem_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_ce_d = 1'b0;
    mem_pc_d = mem_pc_q;
    iq_push  = 1'b0;
    iq_pop   = 1'b0;
    iq_flush = 1'b0;
    if (!rdy) begin
      mem_ce_d = mem_ce_q;
    end else if (in_redirect_ce) begin
      // Any request still in flight must have its response swallowed.
      iq_flush = 1'b1;
      pc_d     = in_redirect_pc;
      state_d  = (state_q != StIdle && !in_mem_ce) ? StDrop : StIdle;
    end else begin
      iq_pop = iq_valid && in_dec_ready;
      unique case (state_q)
        StIdle: begin
          if (iq_count < DepthCnt) begin
            mem_ce_d = 1'b1;
            mem_pc_d = pc_q;
            state_d  = StWaitMem;
          end
        end
        StWaitMem: begin
          if (in_mem_ce) begin
            iq_push = 1'b1;
            pc_d    = next_pc;
            state_d = StIdle;
          end
        end
        StDrop: begin
          if (in_mem_ce) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_mem_ce      = mem_ce_q && rdy;
    out_mem_pc      = mem_pc_q;
    out_instr_valid = iq_valid;
    out_instr       = iq_head[2*XLEN:XLEN+1];
    out_pc          = iq_head[XLEN:1];
`ifdef FETCH_BPRED_EN
    out_pred_taken  = iq_head[0];
`else
    out_pred_taken  = 1'b0;
`endif
  end

endmodule
